osc_capture: RTL and testbench
==============================

OSC_CAPTURE -- requirements
Module: osc_capture

Interface
REQ-001 SHALL have parameter VAL_RES, default 12, the sample width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the buffer address width; DEPTH = 2^ADDR_WIDTH samples.
REQ-003 pixclk  in  1  the single clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 adc_data  in  VAL_RES  unsigned ADC sample.
REQ-006 adc_valid  in  1  adc_data is valid this cycle.
REQ-007 trig_level  in  VAL_RES  unsigned trigger threshold.
REQ-008 trig_rising  in  1  1 selects a rising-edge trigger; 0 selects a falling-edge trigger.
REQ-009 pretrig  in  ADDR_WIDTH  number of samples kept before the trigger sample.
REQ-010 rearm  in  1  single-cycle pulse that discards the frame and starts a new capture.
REQ-011 frame_sync  in  1  single-cycle pulse from the display stage that restarts readout at offset 0.
REQ-012 readValEn  in  1  single-cycle request for the next sample, same meaning as the HDMI stage input.
REQ-013 val  out  VAL_RES  sample delivered to the HDMI stage.
REQ-014 val_valid  out  1  val was updated this cycle.
REQ-015 frame_ready  out  1  a complete frame is frozen and readable.
REQ-016 state  out  2  current state: PRE=0, ARMED=1, POST=2, READY=3.

Function
REQ-017 SHALL store samples in a DEPTH-entry circular RAM: write address wr_ptr advances by 1 (mod DEPTH) per accepted sample.
REQ-018 A sample is accepted only when adc_valid=1 and state is PRE, ARMED or POST; no samples are accepted in READY.
REQ-019 PRE: count accepted samples; after pretrig samples, go to ARMED; pretrig=0 goes to ARMED on the next cycle.
REQ-020 ARMED: a rising trigger fires when prev<trig_level and cur>=trig_level; a falling trigger fires when prev>trig_level and cur<=trig_level. prev is the last accepted sample, cur is the current accepted sample.
REQ-021 No trigger SHALL fire until prev holds a sample accepted since the last reset or rearm.
REQ-022 On trigger: latch trig_addr = the address of cur and go to POST; cur counts as the first post sample.
REQ-023 POST: after DEPTH-pretrig total post samples, including the trigger sample, go to READY and set frame_ready=1 on the same edge.
REQ-024 READY: frame start address start = (trig_addr - pretrig) mod DEPTH; the read offset rd_off is reset to 0 on entry.
REQ-025 A readValEn in READY SHALL produce val = RAM[(start+rd_off) mod DEPTH] with val_valid=1 exactly one cycle later (latency 1), and rd_off advances.
REQ-026 rd_off SHALL wrap from DEPTH-1 to 0.
REQ-027 frame_sync SHALL set rd_off to 0.
REQ-028 When frame_sync and readValEn occur in the same cycle, the read SHALL use offset 0 and rd_off becomes 1.
REQ-029 readValEn outside READY SHALL be ignored: val holds its value and val_valid=0.
REQ-030 rearm in any state SHALL go to PRE, clear frame_ready, the pre-count and prev-valid on the next edge; wr_ptr is kept.
REQ-031 rearm SHALL take priority over a trigger or a POST completion in the same cycle.
REQ-032 A frame_sync outside READY SHALL have no effect.
REQ-033 Changes to pretrig after PRE has been left SHALL not affect the current frame; the value is sampled on entry to ARMED.

Reset
REQ-034 rst_n=0 SHALL asynchronously force: state=PRE, wr_ptr=0, rd_off=0, counts=0, prev-valid=0, val=0, val_valid=0, frame_ready=0.
REQ-035 Reset mid-capture or mid-readout SHALL abandon the frame; RAM contents are not cleared.
REQ-036 Operation SHALL resume on the first pixclk edge after rst_n deasserts.

Verification (ADDR_WIDTH=4, DEPTH=16, trig_level=100, trig_rising=1)
REQ-037 Ramp 0,10,20,... every cycle with pretrig=4 -> trigger on sample 100 (addr 10); READY after samples 100..210 (12 samples); 16 reads return 60..210 with val_valid one cycle after each readValEn.
REQ-038 Continue reading after 16 reads -> the 17th read returns 60 (wrap); frame_sync plus readValEn in the same cycle -> 60, and the next read returns 70.
REQ-039 trig_rising=0 with a descending ramp 200,190,... and pretrig=0 -> trigger on 100; the first read returns 100.
REQ-040 Constant input 150 -> stays in ARMED indefinitely with frame_ready=0; readValEn -> val_valid stays 0.
REQ-041 rearm pulse in READY -> state=PRE and frame_ready=0 next cycle; rearm coincident with the trigger sample -> PRE, no trigger.
REQ-042 rst_n low for 1 cycle during POST -> all outputs 0 and state=PRE immediately; a fresh ramp then captures correctly.

Source files
------------

// File: rtl/osc_capture.sv
// Triggered oscilloscope capture into a circular RAM, read out by the display stage after a frame freezes.
// Capture accepts every valid sample outside READY with no backpressure; readout returns val one cycle after each readValEn.
module osc_capture #(
  parameter int VAL_RES    = 12,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  pixclk,
  input  logic                  rst_n,
  input  logic [VAL_RES-1:0]    adc_data,
  input  logic                  adc_valid,
  input  logic [VAL_RES-1:0]    trig_level,
  input  logic                  trig_rising,
  input  logic [ADDR_WIDTH-1:0] pretrig,
  input  logic                  rearm,
  input  logic                  frame_sync,
  input  logic                  readValEn,
  output logic [VAL_RES-1:0]    val,
  output logic                  val_valid,
  output logic                  frame_ready,
  output logic [1:0]            state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE_P   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {PRE = 2'd0, ARMED = 2'd1, POST = 2'd2, READY = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_WIDTH:0]     post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0]   pretrig_q, pretrig_d;
  logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0]   rd_off_q, rd_off_d;
  logic [VAL_RES-1:0]      prev_q, prev_d;
  logic                    prev_vld_q, prev_vld_d;
  logic                    frame_ready_q, frame_ready_d;
  logic [VAL_RES-1:0]      val_q;
  logic                    val_valid_q;
  logic [VAL_RES-1:0]      mem_q [DEPTH];

  logic                    accept, trig_fire, rd_en;
  logic [ADDR_WIDTH:0]     post_target, post_nxt;
  logic [ADDR_WIDTH-1:0]   pre_nxt, rd_base, rd_addr;

  always_comb begin
    accept      = adc_valid && (state_q != READY);
    post_target = DEPTH_W - {1'b0, pretrig_q};
    post_nxt    = post_cnt_q + ONE_P;
    pre_nxt     = pre_cnt_q + ONE_A;
    trig_fire   = (state_q == ARMED) && accept && prev_vld_q &&
                  (trig_rising ? (prev_q < trig_level && adc_data >= trig_level)
                               : (prev_q > trig_level && adc_data <= trig_level));
    // A same-cycle frame_sync makes this read start the frame again.
    rd_base     = frame_sync ? '0 : rd_off_q;
    rd_addr     = trig_addr_q - pretrig_q + rd_base;
    rd_en       = (state_q == READY) && readValEn;
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pre_cnt_d     = pre_cnt_q;
    post_cnt_d    = post_cnt_q;
    pretrig_d     = pretrig_q;
    trig_addr_d   = trig_addr_q;
    rd_off_d      = rd_off_q;
    prev_d        = prev_q;
    prev_vld_d    = prev_vld_q;
    frame_ready_d = frame_ready_q;

    if (accept) begin
      wr_ptr_d   = wr_ptr_q + ONE_A;
      prev_d     = adc_data;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      PRE: begin
        if (pretrig == '0) begin
          state_d   = ARMED;
          pretrig_d = pretrig;
        end else if (accept) begin
          pre_cnt_d = pre_nxt;
          if (pre_nxt == pretrig) begin
            state_d   = ARMED;
            pretrig_d = pretrig;
          end
        end
      end
      ARMED: begin
        if (trig_fire) begin
          trig_addr_d = wr_ptr_q;
          post_cnt_d  = ONE_P;
          if (post_target == ONE_P) begin
            state_d       = READY;
            frame_ready_d = 1'b1;
            rd_off_d      = '0;
          end else begin
            state_d = POST;
          end
        end
      end
      POST: begin
        if (accept) begin
          post_cnt_d = post_nxt;
          if (post_nxt == post_target) begin
            state_d       = READY;
            frame_ready_d = 1'b1;
            rd_off_d      = '0;
          end
        end
      end
      READY: begin
        if (readValEn)       rd_off_d = rd_base + ONE_A;
        else if (frame_sync) rd_off_d = '0;
      end
      default: state_d = PRE;
    endcase

    if (rearm) begin
      state_d       = PRE;
      frame_ready_d = 1'b0;
      pre_cnt_d     = '0;
      prev_vld_d    = 1'b0;
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PRE;
      wr_ptr_q      <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      pretrig_q     <= '0;
      trig_addr_q   <= '0;
      rd_off_q      <= '0;
      prev_q        <= '0;
      prev_vld_q    <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      pre_cnt_q     <= pre_cnt_d;
      post_cnt_q    <= post_cnt_d;
      pretrig_q     <= pretrig_d;
      trig_addr_q   <= trig_addr_d;
      rd_off_q      <= rd_off_d;
      prev_q        <= prev_d;
      prev_vld_q    <= prev_vld_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  // Sample RAM survives reset so a frozen frame is never wiped by the reset tree.
  always_ff @(posedge pixclk) begin
    if (accept) mem_q[wr_ptr_q] <= adc_data;
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      val_q       <= '0;
      val_valid_q <= 1'b0;
    end else begin
      val_valid_q <= rd_en;
      if (rd_en) val_q <= mem_q[rd_addr];
    end
  end

  assign val         = val_q;
  assign val_valid   = val_valid_q;
  assign frame_ready = frame_ready_q;
  assign state       = state_q;

endmodule

// File: tb/tb_osc_capture.sv
// Directed bench for osc_capture (DEPTH=16): read expectations go to a scoreboard checked by an independent monitor.
module tb_osc_capture;

  logic        pixclk = 1'b0;
  logic        rst_n;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [11:0] trig_level;
  logic        trig_rising;
  logic [3:0]  pretrig;
  logic        rearm;
  logic        frame_sync;
  logic        readValEn;
  logic [11:0] val;
  logic        val_valid;
  logic        frame_ready;
  logic [1:0]  state;

  osc_capture #(.VAL_RES(12), .ADDR_WIDTH(4)) dut (
    .pixclk(pixclk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .trig_level(trig_level), .trig_rising(trig_rising), .pretrig(pretrig),
    .rearm(rearm), .frame_sync(frame_sync), .readValEn(readValEn),
    .val(val), .val_valid(val_valid), .frame_ready(frame_ready), .state(state)
  );

  always #5 pixclk = ~pixclk;

  typedef struct {int v; int c;} exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge pixclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Monitor: every val_valid must match the oldest outstanding read, one cycle after issue.
  always @(negedge pixclk) begin
    if (rst_n === 1'b1 && val_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_val_valid actual=%0d expected=none", val);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("read_val", int'(val), e.v);
        chk("read_latency_cycle", cyc, e.c);
      end
    end
  end

  task automatic tick();
    @(posedge pixclk);
    #1;
    adc_valid  = 1'b0;
    readValEn  = 1'b0;
    frame_sync = 1'b0;
    rearm      = 1'b0;
  endtask

  task automatic sample(input int d);
    adc_data  = 12'(d);
    adc_valid = 1'b1;
    tick();
  endtask

  task automatic rd(input int expv, input bit fs);
    readValEn  = 1'b1;
    frame_sync = fs;
    exp_q.push_back('{expv, cyc + 1});
    tick();
  endtask

  task automatic drain();
    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic ramp_capture(input string tag);
    for (int k = 0; k < 22; k++) begin
      sample(10 * k);
      if (k == 3)  chk({tag, "_armed"}, int'(state), 1);
      if (k == 9)  chk({tag, "_still_armed"}, int'(state), 1);
      if (k == 10) chk({tag, "_post_on_trigger"}, int'(state), 2);
      if (k == 20) chk({tag, "_post_before_end"}, int'(state), 2);
      if (k == 20) chk({tag, "_not_ready_yet"}, int'(frame_ready), 0);
    end
    chk({tag, "_ready_state"}, int'(state), 3);
    chk({tag, "_frame_ready"}, int'(frame_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; adc_data = '0; adc_valid = 1'b0; trig_level = 12'd100;
    trig_rising = 1'b1; pretrig = 4'd4; rearm = 1'b0; frame_sync = 1'b0; readValEn = 1'b0;
    tick(); tick();
    chk("reset_state", int'(state), 0);
    chk("reset_frame_ready", int'(frame_ready), 0);
    chk("reset_val", int'(val), 0);
    chk("reset_val_valid", int'(val_valid), 0);
    rst_n = 1'b1;
    tick();

    // Rising ramp, pretrig=4: frame is 60..210.
    ramp_capture("ramp1");
    for (int i = 0; i < 16; i++) rd(60 + 10 * i, 1'b0);
    tick();
    rd(60, 1'b0);
    rd(60, 1'b1);
    rd(70, 1'b0);
    frame_sync = 1'b1;
    tick();
    rd(60, 1'b0);
    drain();

    // Rearm from READY, then a read outside READY is ignored.
    rearm = 1'b1;
    tick();
    chk("rearm_ready_state", int'(state), 0);
    chk("rearm_ready_frame_ready", int'(frame_ready), 0);
    readValEn = 1'b1;
    tick();
    chk("read_outside_ready_valid", int'(val_valid), 0);
    chk("read_outside_ready_holds", int'(val), 60);

    // Rearm coincident with the trigger sample suppresses the trigger.
    for (int k = 0; k < 10; k++) sample(10 * k);
    chk("pre_trigger_armed", int'(state), 1);
    rearm = 1'b1;
    sample(100);
    chk("rearm_beats_trigger", int'(state), 0);
    tick();
    chk("rearm_beats_trigger_hold", int'(state), 0);
    chk("rearm_beats_trigger_fr", int'(frame_ready), 0);

    // Flat input never crosses the level.
    for (int k = 0; k < 30; k++) begin
      if (k % 5 == 0) readValEn = 1'b1;
      sample(150);
    end
    chk("flat_stays_armed", int'(state), 1);
    chk("flat_no_frame", int'(frame_ready), 0);
    chk("flat_read_ignored", int'(val_valid), 0);

    // Reset during POST, then a fresh capture.
    rearm = 1'b1;
    tick();
    for (int k = 0; k < 13; k++) sample(10 * k);
    chk("before_reset_post", int'(state), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_val", int'(val), 0);
    chk("async_reset_val_valid", int'(val_valid), 0);
    chk("async_reset_frame_ready", int'(frame_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    ramp_capture("ramp2");
    for (int i = 0; i < 16; i++) rd(60 + 10 * i, 1'b0);
    drain();

    // Falling trigger, pretrig=0: frame starts at the trigger sample.
    trig_rising = 1'b0;
    pretrig     = 4'd0;
    rearm       = 1'b1;
    tick();
    for (int k = 0; k < 30; k++) sample((200 - 10 * k) > 0 ? (200 - 10 * k) : 0);
    chk("fall_ready_state", int'(state), 3);
    chk("fall_frame_ready", int'(frame_ready), 1);
    rd(100, 1'b0);
    rd(90, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
